// File: rtl/mem_access_ctrl.sv
// CPU-to-async-RAM sequencer (IDLE->SETUP->STROBE->HOLD); ack at accept+STROBE_CYCLES+1, period STROBE_CYCLES+3.
// Backpressure: ready=0 while busy; req seen then is dropped, so the CPU holds req until ready=1.
module mem_access_ctrl #(
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 4,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_csn,
    output logic              ram_rwn,
    input  logic [DATA_W-1:0] ram_dataout
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_csn, w_csn_nxt;
    logic              r_rwn, w_rwn_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_ack, w_ack_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_csn   <= 1'b1;
            r_rwn   <= 1'b1;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_csn   <= w_csn_nxt;
            r_rwn   <= w_rwn_nxt;
            r_ready <= w_ready_nxt;
            r_ack   <= w_ack_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Every pin value is computed one cycle early and registered, so RAM strobes never glitch.
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_csn_nxt   = 1'b1;
        w_rwn_nxt   = 1'b1;
        w_ready_nxt = 1'b0;
        w_ack_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (req) begin
                    w_we_nxt    = we;
                    w_addr_nxt  = addr;
                    w_wdata_nxt = wdata;
                    w_ready_nxt = 1'b0;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_csn_nxt   = 1'b0;
                w_rwn_nxt   = ~r_we;
                w_cnt_nxt   = CNT_INIT;
                w_state_nxt = STROBE;
            end
            STROBE: begin
                if (r_cnt == 4'd0) begin
                    if (!r_we) begin
                        w_rdata_nxt = ram_dataout;
                    end
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_csn_nxt = 1'b0;
                    w_rwn_nxt = ~r_we;
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            HOLD: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ready      = r_ready;
    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign ram_addr   = r_addr;
    assign ram_datain = r_wdata;
    assign ram_csn    = r_csn;
    assign ram_rwn    = r_rwn;

    a_strobe_cfg: assert property (@(posedge clk) STROBE_CYCLES >= 1 && STROBE_CYCLES <= 15);

    a_pins_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (!ram_csn && $past(!ram_csn)) |-> ($stable(ram_addr) && $stable(ram_datain) && $stable(ram_rwn)));

    a_write_in_select: assert property (@(posedge clk) disable iff (!rst_n)
        !ram_rwn |-> !ram_csn);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Two controllers (STROBE_CYCLES 1 and 3), each with a behavioural RAM;
// issued accesses push expected ack cycle/rdata, a negedge monitor pops and compares.
module tb_mem_access_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] rd;
    } exp_t;

    logic       clk;
    logic       rst_n      [2];
    logic       req        [2];
    logic       we         [2];
    logic [3:0] addr       [2];
    logic [3:0] wdata      [2];
    logic       ready      [2];
    logic       ack        [2];
    logic [3:0] rdata      [2];
    logic [3:0] ram_addr   [2];
    logic [3:0] ram_datain [2];
    logic       ram_csn    [2];
    logic       ram_rwn    [2];
    wire  [3:0] dout0, dout1;

    logic [3:0] mem0 [16];
    logic [3:0] mem1 [16];

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int csn_run  [2] = '{0, 0};
    int csn_len  [2] = '{0, 0};
    int csn_cnt  [2] = '{0, 0};
    int ack_cnt  [2] = '{0, 0};
    logic [3:0] last_addr [2] = '{4'd0, 4'd0};
    logic       last_rwn  [2] = '{1'b1, 1'b1};

    mem_access_ctrl #(.ADDR_W(4), .DATA_W(4), .STROBE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ready(ready[0]), .ack(ack[0]), .rdata(rdata[0]),
        .ram_addr(ram_addr[0]), .ram_datain(ram_datain[0]), .ram_csn(ram_csn[0]),
        .ram_rwn(ram_rwn[0]), .ram_dataout(dout0));

    mem_access_ctrl #(.ADDR_W(4), .DATA_W(4), .STROBE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ready(ready[1]), .ack(ack[1]), .rdata(rdata[1]),
        .ram_addr(ram_addr[1]), .ram_datain(ram_datain[1]), .ram_csn(ram_csn[1]),
        .ram_rwn(ram_rwn[1]), .ram_dataout(dout1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Level-sensitive RAM: output driven only while selected for read.
    assign dout0 = (!ram_csn[0] && ram_rwn[0]) ? mem0[ram_addr[0]] : 4'bzzzz;
    assign dout1 = (!ram_csn[1] && ram_rwn[1]) ? mem1[ram_addr[1]] : 4'bzzzz;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 4'd0;
            mem1[i] = 4'd0;
        end
    end

    always @(negedge clk) begin
        if (!ram_csn[0] && !ram_rwn[0]) mem0[ram_addr[0]] <= ram_datain[0];
        if (!ram_csn[1] && !ram_rwn[1]) mem1[ram_addr[1]] <= ram_datain[1];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n[k]) begin
                if (ack[k]) begin
                    ack_cnt[k] = ack_cnt[k] + 1;
                    if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_ack inst%0d: ack=1 at cycle %0d, expected none", k, cyc);
                    end else begin
                        mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("ack_cycle_inst%0d", k), cyc, mon_e.cyc);
                        chk($sformatf("rdata_inst%0d", k), int'(rdata[k]), int'(mon_e.rd));
                    end
                end
                if (!ram_csn[k]) begin
                    csn_run[k]   = csn_run[k] + 1;
                    last_addr[k] = ram_addr[k];
                    last_rwn[k]  = ram_rwn[k];
                end else if (csn_run[k] != 0) begin
                    csn_len[k] = csn_run[k];
                    csn_cnt[k] = csn_cnt[k] + 1;
                    csn_run[k] = 0;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input int k, input bit w, input int a, input int d,
                         input int exp_r, input bit keep, output int e0);
        int   n;
        exp_t it;
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = 4'(a);
        wdata[k] = 4'(d);
        n = 0;
        while (ready[k] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout inst%0d: ready never 1, required 1", k);
            req[k] = 1'b0;
            e0 = cyc;
        end else begin
            e0     = cyc + 1;
            it.cyc = e0 + ((k == 0) ? 1 : 3) + 1;
            it.rd  = 4'(exp_r);
            if (k == 0) q0.push_back(it);
            else        q1.push_back(it);
            @(negedge clk);
            if (!keep) req[k] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: %0d/%0d acks outstanding, required 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e0, e1, e2, c0, a1;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            req[k]   = 1'b1;
            we[k]    = 1'b0;
            addr[k]  = 4'd0;
            wdata[k] = 4'd0;
        end
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(ready[0]), 1);
        chk("reset_ack", int'(ack[0]), 0);
        chk("reset_csn", int'(ram_csn[0]), 1);
        chk("reset_rwn", int'(ram_rwn[0]), 1);
        chk("reset_rdata", int'(rdata[0]), 0);
        chk("reset_ram_addr", int'(ram_addr[0]), 0);
        chk("reset_ready_inst1", int'(ready[1]), 1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        issue(0, 1'b0, 0, 0, 0, 1'b0, e0);
        chk("accepted_first_edge", int'(ready[0]), 0);
        drain();

        issue(0, 1'b1, 5, 'hA, 0, 1'b0, e0);
        drain();
        chk("wr5_csn_len", csn_len[0], 1);
        chk("wr5_rwn", int'(last_rwn[0]), 0);
        chk("wr5_addr", int'(last_addr[0]), 5);
        issue(0, 1'b0, 5, 0, 'hA, 1'b0, e0);
        drain();
        chk("rd5_csn_len", csn_len[0], 1);
        chk("rd5_rwn", int'(last_rwn[0]), 1);

        c0 = csn_cnt[0];
        issue(0, 1'b1, 3, 7, 'hA, 1'b1, e0);
        issue(0, 1'b0, 3, 0, 7, 1'b1, e1);
        issue(0, 1'b0, 9, 0, 0, 1'b0, e2);
        drain();
        chk("b2b_period_1", e1 - e0, 4);
        chk("b2b_period_2", e2 - e1, 4);
        chk("b2b_ram_cycles", csn_cnt[0] - c0, 3);

        c0 = csn_cnt[0];
        issue(0, 1'b0, 6, 0, 0, 1'b0, e0);
        @(negedge clk);
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 4'd2;
        wdata[0] = 4'hF;
        @(negedge clk);
        req[0] = 1'b0;
        drain();
        chk("busy_req_ram_cycles", csn_cnt[0] - c0, 1);
        issue(0, 1'b0, 2, 0, 0, 1'b0, e0);
        drain();

        issue(1, 1'b1, 15, 'hF, 0, 1'b0, e0);
        drain();
        chk("s3_wr_csn_len", csn_len[1], 3);
        chk("s3_wr_rwn", int'(last_rwn[1]), 0);
        issue(1, 1'b0, 15, 0, 'hF, 1'b0, e0);
        drain();
        chk("s3_rd_csn_len", csn_len[1], 3);
        chk("s3_rd_addr", int'(last_addr[1]), 15);

        a1 = ack_cnt[1];
        issue(1, 1'b1, 8, 5, 0, 1'b0, e0);
        @(negedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        chk("abort_csn", int'(ram_csn[1]), 1);
        chk("abort_rwn", int'(ram_rwn[1]), 1);
        chk("abort_ready", int'(ready[1]), 1);
        chk("abort_rdata", int'(rdata[1]), 0);
        q1.delete();
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_ack", ack_cnt[1] - a1, 0);
        issue(1, 1'b0, 8, 0, 5, 1'b0, e0);
        drain();

        chk("scoreboard_empty", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Synchronous sequencer between the 4-bit CPU datapath and the asynchronous, level-sensitive 16x4 RAM.
- Converts single-cycle CPU load/store requests into glitch-free RAM cycles with address setup, strobe and recovery phases.
- On reads, captures the RAM's tri-state output into a register and returns it to the CPU with a one-cycle ack.

Parameters:
ADDR_W, 4, address width (RAM depth 2**ADDR_W)
DATA_W, 4, data width
STROBE_CYCLES, 1, cycles csn is held low per access; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  CPU access request, sampled only when ready=1
we  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  CPU address; sampled with req
wdata  in  DATA_W  CPU write data; sampled with req
ready  out  1  controller idle, can accept req
ack  out  1  one-cycle pulse, access complete
rdata  out  DATA_W  last read data; valid from ack of a read until the next read's ack
ram_addr  out  ADDR_W  to RAM addr
ram_datain  out  DATA_W  to RAM datain
ram_csn  out  1  to RAM chip select, active low
ram_rwn  out  1  to RAM read/write (1 = read, 0 = write)
ram_dataout  in  DATA_W  from RAM tri-state output

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; ready = 1; ack = 0; rdata = 0.
  - ram_addr = 0; ram_datain = 0; ram_csn = 1; ram_rwn = 1.
  - Strobe counter = 0.
  - Assertion takes effect immediately, without waiting for a clock edge.
- All outputs come directly from flops. No combinational decode to RAM pins; the RAM write is level-sensitive and must never glitch.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - ready = 1, ram_csn = 1, ram_rwn = 1.
  - On an edge with req = 1: latch we, addr and wdata; drive ram_addr/ram_datain; go to SETUP.
- SETUP (1 cycle):
  - ram_addr/ram_datain stable; ram_csn = 1, ram_rwn = 1; ready = 0.
  - At the edge: ram_csn <= 0; ram_rwn <= ~we_latched; counter <= STROBE_CYCLES-1; go to STROBE.
- STROBE (STROBE_CYCLES cycles):
  - ram_csn = 0; ram_rwn per op; ram_addr/ram_datain held.
  - Counter decrements each edge.
  - On the edge where counter = 0:
    - for a read, rdata <= ram_dataout;
    - ram_csn <= 1, ram_rwn <= 1, ack <= 1; go to HOLD.
- HOLD (1 cycle):
  - ack = 1; ram_csn = 1, ram_rwn = 1; ram_addr/ram_datain still held (address hold after deselect).
  - Next edge: ack <= 0; go to IDLE.
- Ordering invariants (assertions):
  - ram_addr and ram_datain never change while ram_csn = 0.
  - ram_rwn never changes while ram_csn = 0.
  - ram_rwn = 0 only while ram_csn = 0.
- Latency:
  - Accept edge E0, ack high during cycle [E0+S+1, E0+S+2), where S = STROBE_CYCLES.
  - Earliest next accept is edge E0+S+3; back-to-back period is S+3 cycles.
- req while ready = 0 is ignored, not queued. The CPU must hold req until it sees ready = 1. A req held high through HOLD is accepted at the first IDLE edge.
- Writes leave rdata unchanged. A read of a never-written address returns 0, since the RAM initialises to zero.
- Reset mid-operation:
  - csn/rwn return high asynchronously and no ack is issued.
  - A write aborted during STROBE may or may not have updated the RAM; the CPU must reissue it.
- Out-of-range STROBE_CYCLES (0 or above 15) is a configuration error, flagged by a simulation-time check.

Test Plan:
- Reset: rst_n low for 3 cycles with req=1 -> ready=1, ack=0, ram_csn=1, ram_rwn=1, rdata=0; release -> req accepted on the first edge.
- Write then read, S=1: write addr=5, wdata=0xA -> ram_csn low exactly 1 cycle with ram_rwn=0, ram_addr=5. Then read addr=5 -> ack 2 cycles after the accept edge, rdata=0xA.
- Back-to-back: req held high for write 3<-0x7, read 3, read 9 (unwritten) -> exactly one ack per access, period 4 cycles, rdata=0x7 then 0x0.
- S=3: read addr=15 after writing 0xF -> ram_csn low 3 cycles, ack at accept+4, rdata=0xF. Assertions hold: no addr/rwn change while csn=0.
- Busy request: pulse req (addr=2, we=1) during STROBE -> ignored; no second RAM cycle; RAM[2] unchanged on readback.
- Async reset in STROBE of a write: rst_n low mid-strobe -> ram_csn=1 in the same timestep; no ack; FSM in IDLE. A subsequent read of that address completes normally.
